// File: rtl/ila_core_if.sv
// Simple valid/ready memory bus into the ILA register window.
// The master issues one access per request; the slave acknowledges it one cycle later.
interface ila_core_if;
   logic        bus_valid;
   logic [13:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ready;

   modport master (
      output bus_valid, bus_addr, bus_wstrb, bus_wdata,
      input  bus_rdata, bus_ready
   );

   modport slave (
      input  bus_valid, bus_addr, bus_wstrb, bus_wdata,
      output bus_rdata, bus_ready
   );
endinterface

// File: rtl/ila_core.sv
// ILA capture engine: circular probe sample RAM, mask/value trigger, post-trigger
// sample count and a CPU-visible register window with the sample RAM behind it.
module ila_core #(
   parameter int WIDTH      = 32,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] probe,
   ila_core_if.slave        bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [31:0] INFO = {16'h11A0, 8'(DEPTH_LOG2), 8'(WIDTH)};

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

   state_t                state;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] trig_idx;
   logic [DEPTH_LOG2-1:0] post_cnt;
   logic [DEPTH_LOG2-1:0] trig_post;
   logic [WIDTH-1:0]      trig_mask;
   logic [WIDTH-1:0]      trig_value;
   logic                  running;
   logic                  triggered;
   logic                  done;
   logic                  force_q;

   logic [WIDTH-1:0]      mem [DEPTH];

   logic                  accept;
   logic                  wr_acc;
   logic                  start_cmd;
   logic                  stop_cmd;
   logic                  force_cmd;
   logic                  capturing;
   logic                  match;
   logic [10:0]           ram_word;
   logic [DEPTH_LOG2-1:0] ram_idx;
   logic                  ram_hit;
   logic [31:0]           read_data;

   // A request is taken once; the ready cycle itself never starts a second access.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch can be inferred.
      accept    = bus.bus_valid && !bus.bus_ready;
      wr_acc    = accept && (bus.bus_wstrb != 4'b0);
      start_cmd = 1'b0;
      stop_cmd  = 1'b0;
      force_cmd = 1'b0;
      if (wr_acc && bus.bus_addr == 14'h0004) begin
         stop_cmd  = bus.bus_wdata[1];
         start_cmd = bus.bus_wdata[0] && !bus.bus_wdata[1];
         force_cmd = bus.bus_wdata[2];
      end
      capturing = (state == S_ARMED) || (state == S_POST);
      match     = (((probe ^ trig_value) & trig_mask) == '0) || force_q;
      ram_word  = bus.bus_addr[12:2];
      ram_idx   = DEPTH_LOG2'(ram_word);
      ram_hit   = bus.bus_addr[13] && (int'(ram_word) < DEPTH);
   end

   always_comb begin
      read_data = '0;
      if (ram_hit) begin
         read_data = 32'(mem[ram_idx]);
      end else begin
         case (bus.bus_addr)
            14'h0000: read_data = INFO;
            14'h0008: read_data = {29'b0, done, triggered, running};
            14'h000C: read_data = 32'(trig_post);
            14'h0010: read_data = 32'(trig_idx);
            14'h0014: read_data = 32'(trig_mask);
            14'h0018: read_data = 32'(trig_value);
            default:  read_data = '0;
         endcase
      end
   end

   // NOTE: the sample RAM has no reset so it maps onto block RAM; its contents after reset are undefined.
   always_ff @(posedge clk) begin
      if (capturing) mem[wr_ptr] <= probe;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.bus_ready <= 1'b0;
         bus.bus_rdata <= '0;
         trig_post     <= '0;
         trig_mask     <= '0;
         trig_value    <= '0;
      end else begin
         // NOTE: sequential state always uses non-blocking assignments.
         bus.bus_ready <= accept;
         bus.bus_rdata <= (accept && !wr_acc) ? read_data : '0;
         if (wr_acc) begin
            case (bus.bus_addr)
               14'h000C: trig_post  <= bus.bus_wdata[DEPTH_LOG2-1:0];
               14'h0014: trig_mask  <= bus.bus_wdata[WIDTH-1:0];
               14'h0018: trig_value <= bus.bus_wdata[WIDTH-1:0];
               default:  ;
            endcase
         end
      end
   end

   // Commands override the state's own progression; force is held one edge so it
   // applies to the sample written on the edge after the CTRL write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         wr_ptr    <= '0;
         trig_idx  <= '0;
         post_cnt  <= '0;
         running   <= 1'b0;
         triggered <= 1'b0;
         done      <= 1'b0;
         force_q   <= 1'b0;
      end else begin
         force_q <= force_cmd;
         if (stop_cmd) begin
            state   <= S_IDLE;
            running <= 1'b0;
         end else if (start_cmd) begin
            state     <= S_ARMED;
            wr_ptr    <= '0;
            running   <= 1'b1;
            triggered <= 1'b0;
            done      <= 1'b0;
         end else begin
            case (state)
               S_ARMED: begin
                  wr_ptr <= wr_ptr + 1'b1;
                  if (match) begin
                     trig_idx  <= wr_ptr;
                     triggered <= 1'b1;
                     post_cnt  <= trig_post;
                     if (trig_post == '0) begin
                        state   <= S_DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                     end else begin
                        state <= S_POST;
                     end
                  end
               end
               S_POST: begin
                  wr_ptr   <= wr_ptr + 1'b1;
                  post_cnt <= post_cnt - 1'b1;
                  if (post_cnt == DEPTH_LOG2'(1)) begin
                     state   <= S_DONE;
                     running <= 1'b0;
                     done    <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule
